hammer_inventory: RTL and testbench

//   Owns the player's hammer stock and the timed hammer power-up. Sits directly

---
 rtl/hammer_inventory_if.sv | 37 +++
 rtl/hammer_inventory.sv | 115 +++++++++++
 tb/tb_hammer_inventory.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hammer_inventory_if.sv
// Hammer inventory bus: frame/game/key/pickup in, stock and power-up status out.
// The master drives requests; the slave is the inventory itself.
interface hammer_inventory_if;
  logic       startOfFrame;
  logic       newGame;
  logic       useKey;
  logic       pickup;
  logic [2:0] amount;
  logic       hammerActive;
  logic       coolingDown;
  logic       usePulse;
  logic [7:0] framesLeft;

  modport master (
    output startOfFrame,
    output newGame,
    output useKey,
    output pickup,
    input  amount,
    input  hammerActive,
    input  coolingDown,
    input  usePulse,
    input  framesLeft
  );

  modport slave (
    input  startOfFrame,
    input  newGame,
    input  useKey,
    input  pickup,
    output amount,
    output hammerActive,
    output coolingDown,
    output usePulse,
    output framesLeft
  );
endinterface

// File: rtl/hammer_inventory.sv
// Hammer stock counter plus the ACTIVE/COOLDOWN power-up timer.
// All outputs come straight from registers.
module hammer_inventory #(
  parameter int unsigned HAMMERS_MAX     = 3,
  parameter int unsigned HAMMERS_INIT    = 3,
  parameter int unsigned ACTIVE_FRAMES   = 120,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input logic               clk,
  input logic               reset,
  hammer_inventory_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_COOL
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] timer_q;
  logic [7:0] timer_d;
  logic [2:0] amount_q;
  logic [2:0] amount_d;
  logic       pulse_q;
  logic       pulse_d;
  logic       key_q;
  logic       use_rise;
  logic       accept;
  logic [3:0] sum;

  assign use_rise = bus.useKey & ~key_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    amount_d = amount_q;
    pulse_d  = 1'b0;
    accept   = 1'b0;
    sum      = '0;
    if (bus.newGame) begin
      amount_d = 3'(HAMMERS_INIT);
      state_d  = S_IDLE;
      timer_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (use_rise && amount_q != 3'd0) begin
            accept  = 1'b1;
            pulse_d = 1'b1;
            state_d = S_ACTIVE;
            timer_d = 8'(ACTIVE_FRAMES);
          end
        end
        S_ACTIVE: begin
          if (bus.startOfFrame && timer_q != 8'd0) begin
            if (timer_q == 8'd1) begin
              state_d = S_COOL;
              timer_d = 8'(COOLDOWN_FRAMES);
            end else begin
              timer_d = timer_q - 8'd1;
            end
          end
        end
        S_COOL: begin
          if (bus.startOfFrame && timer_q != 8'd0) begin
            if (timer_q == 8'd1) begin
              state_d = S_IDLE;
              timer_d = '0;
            end else begin
              timer_d = timer_q - 8'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
      // acceptance used the pre-pickup amount; a pickup+use nets to zero
      sum = {1'b0, amount_q}
          + {3'b000, bus.pickup}
          - {3'b000, accept};
      if (sum > 4'(HAMMERS_MAX)) begin
        amount_d = 3'(HAMMERS_MAX);
      end else begin
        amount_d = sum[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      amount_q <= 3'(HAMMERS_INIT);
      pulse_q  <= 1'b0;
      key_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      amount_q <= amount_d;
      pulse_q  <= pulse_d;
      key_q    <= bus.useKey;
    end
  end

  assign bus.amount       = amount_q;
  assign bus.hammerActive = (state_q == S_ACTIVE);
  assign bus.coolingDown  = (state_q == S_COOL);
  assign bus.usePulse     = pulse_q;
  assign bus.framesLeft   = timer_q;

endmodule

// File: tb/tb_hammer_inventory.sv
// Scoreboarded bench for hammer_inventory: a behavioural model queues the
// expected outputs for each driven cycle; scenario tasks pop and compare.
module tb_hammer_inventory;

  typedef struct packed {
    logic [2:0] amount;
    logic       act;
    logic       cool;
    logic       pulse;
    logic [7:0] frames;
  } obs_t;

  logic clk;
  logic reset;
  hammer_inventory_if bus ();

  hammer_inventory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  obs_t sb[$];
  obs_t exp_o;
  obs_t got_o;

  // reference model state: 0 idle, 1 active, 2 cooldown
  int   m_amt;
  int   m_st;
  int   m_tmr;
  bit   m_pulse;
  bit   m_kd;

  function automatic obs_t sample();
    obs_t o;
    o.amount = bus.amount;
    o.act    = bus.hammerActive;
    o.cool   = bus.coolingDown;
    o.pulse  = bus.usePulse;
    o.frames = bus.framesLeft;
    return o;
  endfunction

  task automatic model_reset();
    m_amt   = 3;
    m_st    = 0;
    m_tmr   = 0;
    m_pulse = 1'b0;
    m_kd    = 1'b1;
  endtask

  // drive one cycle, advance the model, queue what the DUT must show
  task automatic cyc(input bit sof, input bit ng, input bit uk, input bit pu);
    bit rise;
    int a;
    obs_t e;
    bus.startOfFrame = sof;
    bus.newGame      = ng;
    bus.useKey       = uk;
    bus.pickup       = pu;
    rise    = uk && !m_kd;
    m_kd    = uk;
    m_pulse = 1'b0;
    if (ng) begin
      m_amt = 3;
      m_st  = 0;
      m_tmr = 0;
    end else begin
      a = m_amt + (pu ? 1 : 0);
      if (m_st == 0) begin
        if (rise && m_amt > 0) begin
          m_st    = 1;
          m_tmr   = 120;
          m_pulse = 1'b1;
          a       = a - 1;
        end
      end else if (sof) begin
        if (m_tmr > 1) m_tmr = m_tmr - 1;
        else if (m_st == 1) begin
          m_st  = 2;
          m_tmr = 30;
        end else begin
          m_st  = 0;
          m_tmr = 0;
        end
      end
      m_amt = (a > 3) ? 3 : a;
    end
    @(posedge clk);
    #1;
    e.amount = 3'(m_amt);
    e.act    = (m_st == 1);
    e.cool   = (m_st == 2);
    e.pulse  = m_pulse;
    e.frames = 8'(m_tmr);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    bus.startOfFrame = 1'b0;
    bus.newGame      = 1'b0;
    bus.useKey       = 1'b1;
    bus.pickup       = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    got_o = sample();
    checks++;
    if (got_o !== 14'h1800) begin
      errors++;
      $display("FAIL reset_vals got=%h exp=%h", got_o, 14'h1800);
    end
    #3 reset = 1'b0;
    // key still held high: no use must fire
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, (i < 2), 1'b0);
      exp_o = sb.pop_front();
      got_o = sample();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL held_key c%0d got=%h exp=%h", i, got_o, exp_o);
      end
    end
  endtask

  task automatic test_use();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    exp_o = sb.pop_front();
    got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL use_sb got=%h exp=%h", got_o, exp_o);
    end
    checks++;
    if (bus.amount !== 3'd2 || bus.usePulse !== 1'b1 ||
        bus.hammerActive !== 1'b1 || bus.framesLeft !== 8'd120) begin
      errors++;
      $display("FAIL use_const got=%h exp=%h", got_o, {3'd2, 3'b101, 8'd120});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_o = sb.pop_front();
    got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL use_pulse_end got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_timers();
    // key toggles throughout ACTIVE and COOLDOWN must be ignored
    for (int i = 0; i < 150; i++) begin
      cyc(1'b1, 1'b0, i[0], 1'b0);
      exp_o = sb.pop_front();
      got_o = sample();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL timers f%0d got=%h exp=%h", i, got_o, exp_o);
      end
      if (i == 118 || i == 119) begin
        checks++;
        if (bus.hammerActive !== (i == 118) || bus.framesLeft !== ((i == 118) ? 8'd1 : 8'd30)) begin
          errors++;
          $display("FAIL phase_edge f%0d got=%h", i, got_o);
        end
      end
    end
    checks++;
    if (got_o !== {3'd2, 3'b000, 8'd0}) begin
      errors++;
      $display("FAIL back_idle got=%h exp=%h", got_o, {3'd2, 3'b000, 8'd0});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      exp_o = sb.pop_front();
      got_o = sample();
      checks++;
      if (got_o !== exp_o || bus.amount !== 3'd3) begin
        errors++;
        $display("FAIL saturate p%0d got=%h exp=%h", i, got_o, exp_o);
      end
    end
  endtask

  task automatic test_zero();
    bit [3:0] st [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'b0000};
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 150; i++) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        exp_o = sb.pop_front();
        got_o = sample();
        checks++;
        if (got_o !== exp_o) begin
          errors++;
          $display("FAIL drain u%0d f%0d got=%h exp=%h", k, i, got_o, exp_o);
        end
      end
    end
    checks++;
    if (bus.amount !== 3'd0) begin
      errors++;
      $display("FAIL empty got=%0d exp=0", bus.amount);
    end
    // {sof,ng,uk,pu}: rejected use, then pickup+use at zero
    for (int i = 0; i < 5; i++) begin
      cyc(st[i][3], st[i][2], st[i][1], st[i][0]);
      exp_o = sb.pop_front();
      got_o = sample();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL zero s%0d got=%h exp=%h", i, got_o, exp_o);
      end
    end
    checks++;
    if (got_o !== {3'd1, 3'b000, 8'd0}) begin
      errors++;
      $display("FAIL zero_pick got=%h exp=%h", got_o, {3'd1, 3'b000, 8'd0});
    end
  endtask

  task automatic test_coincident();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    exp_o = sb.pop_front();
    got_o = sample();
    checks++;
    if (got_o !== exp_o || got_o !== {3'd2, 3'b101, 8'd120}) begin
      errors++;
      $display("FAIL coincident got=%h exp=%h", got_o, exp_o);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
  endtask

  task automatic test_newgame();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
      end
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      exp_o = sb.pop_front();
      got_o = sample();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL ng_use u%0d got=%h exp=%h", k, got_o, exp_o);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    checks++;
    if (bus.amount !== 3'd0 || bus.hammerActive !== 1'b1) begin
      errors++;
      $display("FAIL ng_pre got=%h", sample());
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    exp_o = sb.pop_front();
    got_o = sample();
    checks++;
    if (got_o !== exp_o || got_o !== {3'd3, 3'b000, 8'd0}) begin
      errors++;
      $display("FAIL newgame got=%h exp=%h", got_o, exp_o);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 125; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    got_o = sample();
    checks++;
    if (got_o !== {3'd2, 3'b010, 8'd25}) begin
      errors++;
      $display("FAIL pre_reset got=%h exp=%h", got_o, {3'd2, 3'b010, 8'd25});
    end
    bus.startOfFrame = 1'b0;
    #2 reset = 1'b1;
    #1;
    got_o = sample();
    checks++;
    if (got_o !== {3'd3, 3'b000, 8'd0}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", got_o, {3'd3, 3'b000, 8'd0});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_o = sb.pop_front();
    got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL post_reset got=%h exp=%h", got_o, exp_o);
    end
  endtask

  initial begin
    test_reset();
    test_use();
    test_timers();
    test_saturate();
    test_zero();
    test_coincident();
    test_newgame();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
